// File: rtl/frec_div_ctrl.sv
// Run/stop and reconfiguration controller around a half-period counter and toggle flop.
// New divisors are applied only at toggle boundaries, so the divided clock never produces a runt pulse.
module frec_div_ctrl #(
    parameter int CNT_W    = 27,
    parameter int DEF_HALF = 25000000,
    parameter int BURST_W  = 16
) (
    input  logic               clk_intput,
    input  logic               rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CNT_W-1:0]   cfg_half,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic               start,
    input  logic               stop,
    output logic               clk_output,
    output logic               tick,
    output logic               busy,
    output logic               done,
    output logic [BURST_W-1:0] edges_left
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RUN      = 2'd1;
    localparam logic [1:0] STOPPING = 2'd2;

    logic [1:0]         state;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   active_half;
    logic [BURST_W-1:0] active_burst;
    logic               pend_valid;
    logic [CNT_W-1:0]   pend_half;
    logic [BURST_W-1:0] pend_burst;
    logic               burst_mode;

    logic               cfg_hs;
    logic [CNT_W-1:0]   half_in;
    logic [BURST_W-1:0] launch_burst;
    logic               at_end;
    logic               toggle;
    logic               rise;
    logic               fall;
    logic               stop_now;
    logic               finish;

    // A stop while low, or on the falling toggle itself, ends the run at once;
    // a stop while high must wait for the fall so the last high phase is full length.
    always_comb begin
        half_in      = (cfg_half == '0) ? CNT_W'(1) : cfg_half;
        cfg_ready    = (state == IDLE) || !pend_valid;
        cfg_hs       = cfg_valid && cfg_ready;
        busy         = (state != IDLE);
        launch_burst = cfg_hs ? cfg_burst : active_burst;
        at_end       = (count == active_half - CNT_W'(1));
        toggle       = busy && at_end;
        rise         = toggle && !clk_output;
        fall         = toggle && clk_output;
        stop_now     = (state == RUN) && stop && (!clk_output || fall);
        finish       = stop_now ||
                       (fall && ((state == STOPPING) || (burst_mode && (edges_left == '0))));
    end

    always_ff @(posedge clk_intput) begin
        if (!rst_n) begin
            state        <= IDLE;
            count        <= '0;
            active_half  <= CNT_W'(DEF_HALF);
            active_burst <= '0;
            pend_valid   <= 1'b0;
            pend_half    <= '0;
            pend_burst   <= '0;
            burst_mode   <= 1'b0;
            clk_output   <= 1'b0;
            tick         <= 1'b0;
            done         <= 1'b0;
            edges_left   <= '0;
        end else begin
            tick <= 1'b0;
            done <= 1'b0;
            if (state == IDLE) begin
                if (cfg_hs) begin
                    active_half  <= half_in;
                    active_burst <= cfg_burst;
                end
                if (start && !stop) begin
                    state      <= RUN;
                    count      <= '0;
                    clk_output <= 1'b0;
                    edges_left <= launch_burst;
                    burst_mode <= (launch_burst != '0);
                end
            end else if (finish) begin
                state      <= IDLE;
                done       <= 1'b1;
                count      <= '0;
                clk_output <= 1'b0;
                edges_left <= '0;
                burst_mode <= 1'b0;
                // A configuration still waiting for a boundary lands as we go idle.
                if (pend_valid) begin
                    active_half  <= pend_half;
                    active_burst <= pend_burst;
                    pend_valid   <= 1'b0;
                end else if (cfg_hs) begin
                    active_half  <= half_in;
                    active_burst <= cfg_burst;
                end
            end else begin
                if ((state == RUN) && stop && clk_output) begin
                    state <= STOPPING;
                end
                if (toggle) begin
                    count      <= '0;
                    clk_output <= !clk_output;
                    if (rise) begin
                        tick <= 1'b1;
                        if (burst_mode) begin
                            edges_left <= edges_left - BURST_W'(1);
                        end
                    end
                    if (pend_valid) begin
                        active_half  <= pend_half;
                        active_burst <= pend_burst;
                        pend_valid   <= 1'b0;
                    end
                end else begin
                    count <= count + CNT_W'(1);
                end
                if (cfg_hs) begin
                    pend_valid <= 1'b1;
                    pend_half  <= half_in;
                    pend_burst <= cfg_burst;
                end
            end
        end
    end

endmodule

// File: tb/tb_frec_div_ctrl.sv
// Self-checking bench for frec_div_ctrl: randomized scenarios compared against
// expected waveforms derived arithmetically from half-period and toggle-time rules.
module tb_frec_div_ctrl;

    localparam int CW   = 27;
    localparam int BW   = 16;
    localparam int DEFH = 5;

    logic          clk_intput = 1'b0;
    logic          rst_n      = 1'b0;
    logic          cfg_valid  = 1'b0;
    logic [CW-1:0] cfg_half   = '0;
    logic [BW-1:0] cfg_burst  = '0;
    logic          start      = 1'b0;
    logic          stop       = 1'b0;
    logic          cfg_ready;
    logic          clk_output;
    logic          tick;
    logic          busy;
    logic          done;
    logic [BW-1:0] edges_left;

    int checks   = 0;
    int failures = 0;

    frec_div_ctrl #(.CNT_W(CW), .DEF_HALF(DEFH), .BURST_W(BW)) dut (
        .clk_intput(clk_intput),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_half  (cfg_half),
        .cfg_burst (cfg_burst),
        .start     (start),
        .stop      (stop),
        .clk_output(clk_output),
        .tick      (tick),
        .busy      (busy),
        .done      (done),
        .edges_left(edges_left)
    );

    always #5 clk_intput = ~clk_intput;

    task automatic step();
        @(posedge clk_intput);
        #1;
    endtask

    // Handshake a configuration and start in the same cycle; returns just after that edge.
    task automatic launch(input int h, input int b);
        cfg_valid = 1'b1;
        cfg_half  = CW'(h);
        cfg_burst = BW'(b);
        start     = 1'b1;
        step();
        cfg_valid = 1'b0;
        start     = 1'b0;
        cfg_burst = '0;
    endtask

    task automatic drain(input int bound);
        int i;
        stop = 1'b1;
        step();
        stop = 1'b0;
        i = 0;
        while (busy && i < bound) begin
            step();
            i++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL drain_idle got busy=%0b required 0", busy);
        end
    endtask

    task automatic test_reset();
        logic e;
        rst_n = 1'b0;
        step();
        step();
        checks += 6;
        if (clk_output !== 1'b0) begin failures++; $display("FAIL rst_clk got=%0b exp=0", clk_output); end
        if (tick !== 1'b0)       begin failures++; $display("FAIL rst_tick got=%0b exp=0", tick); end
        if (done !== 1'b0)       begin failures++; $display("FAIL rst_done got=%0b exp=0", done); end
        if (busy !== 1'b0)       begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy); end
        if (edges_left !== '0)   begin failures++; $display("FAIL rst_edges got=%0d exp=0", edges_left); end
        if (cfg_ready !== 1'b1)  begin failures++; $display("FAIL rst_ready got=%0b exp=1", cfg_ready); end
        rst_n = 1'b1;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 1; n <= DEFH; n++) begin
            step();
            e = (n == DEFH);
            checks += 2;
            if (clk_output !== e) begin failures++; $display("FAIL rst_defh_clk n=%0d got=%0b exp=%0b", n, clk_output, e); end
            if (tick !== e)       begin failures++; $display("FAIL rst_defh_tick n=%0d got=%0b exp=%0b", n, tick, e); end
        end
        drain(2 * DEFH + 2);
    endtask

    task automatic test_continuous();
        int h;
        logic e_clk, e_tick;
        for (int rep = 0; rep < 4; rep++) begin
            h = (rep == 0) ? 2 : $urandom_range(1, 6);
            launch(h, 0);
            for (int n = 1; n <= 4 * h + 1; n++) begin
                step();
                e_clk  = ((n / h) % 2) == 1;
                e_tick = ((n % h) == 0) && e_clk;
                checks += 4;
                if (clk_output !== e_clk) begin failures++; $display("FAIL cont_clk h=%0d n=%0d got=%0b exp=%0b", h, n, clk_output, e_clk); end
                if (tick !== e_tick)      begin failures++; $display("FAIL cont_tick h=%0d n=%0d got=%0b exp=%0b", h, n, tick, e_tick); end
                if (busy !== 1'b1)        begin failures++; $display("FAIL cont_busy h=%0d n=%0d got=%0b exp=1", h, n, busy); end
                if (edges_left !== '0)    begin failures++; $display("FAIL cont_edges h=%0d n=%0d got=%0d exp=0", h, n, edges_left); end
            end
            drain(2 * h + 2);
        end
    endtask

    task automatic test_burst();
        int h, he, b, nn, ticks, dones, eb;
        logic sae, run, e_clk, e_tick;
        for (int rep = 0; rep < 5; rep++) begin
            h   = (rep == 0) ? 1 : (rep == 1) ? 0 : $urandom_range(1, 4);
            b   = (rep == 0) ? 3 : (rep == 1) ? 2 : $urandom_range(1, 4);
            sae = (rep == 4);
            he  = (h == 0) ? 1 : h;
            nn  = 2 * he * b;
            launch(h, b);
            checks++;
            if (edges_left !== BW'(b)) begin failures++; $display("FAIL burst_load got=%0d exp=%0d", edges_left, b); end
            ticks = 0;
            dones = 0;
            for (int n = 1; n <= nn + 2; n++) begin
                stop = sae && (n == nn);
                step();
                stop = 1'b0;
                run    = (n < nn);
                e_clk  = run && (((n / he) % 2) == 1);
                e_tick = e_clk && ((n % he) == 0);
                eb     = run ? b - ((n / he) + 1) / 2 : 0;
                if (tick === 1'b1) ticks++;
                if (done === 1'b1) dones++;
                checks += 5;
                if (clk_output !== e_clk)    begin failures++; $display("FAIL burst_clk h=%0d b=%0d n=%0d got=%0b exp=%0b", h, b, n, clk_output, e_clk); end
                if (tick !== e_tick)         begin failures++; $display("FAIL burst_tick h=%0d b=%0d n=%0d got=%0b exp=%0b", h, b, n, tick, e_tick); end
                if (edges_left !== BW'(eb))  begin failures++; $display("FAIL burst_edges h=%0d b=%0d n=%0d got=%0d exp=%0d", h, b, n, edges_left, eb); end
                if (done !== (n == nn))      begin failures++; $display("FAIL burst_done h=%0d b=%0d n=%0d got=%0b exp=%0b", h, b, n, done, n == nn); end
                if (busy !== run)            begin failures++; $display("FAIL burst_busy h=%0d b=%0d n=%0d got=%0b exp=%0b", h, b, n, busy, run); end
            end
            checks += 2;
            if (ticks != b)  begin failures++; $display("FAIL burst_tick_count got=%0d exp=%0d", ticks, b); end
            if (dones != 1)  begin failures++; $display("FAIL burst_done_count got=%0d exp=1", dones); end
        end
    endtask

    task automatic test_reconfig();
        int ho, hn, a, tj, lim, prev, cnt;
        int tq[$];
        logic e_clk, e_tick, e_rdy;
        for (int rep = 0; rep < 3; rep++) begin
            ho  = (rep == 0) ? 4 : $urandom_range(2, 5);
            hn  = (rep == 0) ? 2 : $urandom_range(1, 5);
            a   = (rep == 0) ? 2 : $urandom_range(1, 3 * ho);
            lim = a + ho + 4 * hn + 2;
            // Halves starting after the handshake edge use the new length.
            tq.delete();
            prev = 0;
            tj   = -1;
            while (prev <= lim) begin
                prev += (prev > a) ? hn : ho;
                tq.push_back(prev);
                if (tj < 0 && prev > a) tj = prev;
            end
            launch(ho, 0);
            for (int n = 1; n <= lim; n++) begin
                cfg_valid = (n == a);
                cfg_half  = CW'(hn);
                step();
                cfg_valid = 1'b0;
                cnt    = 0;
                e_tick = 1'b0;
                foreach (tq[i]) begin
                    if (tq[i] <= n) cnt++;
                    if (tq[i] == n && (i % 2) == 0) e_tick = 1'b1;
                end
                e_clk = (cnt % 2) == 1;
                e_rdy = !(n >= a && n < tj);
                checks += 3;
                if (clk_output !== e_clk) begin failures++; $display("FAIL recfg_clk ho=%0d hn=%0d a=%0d n=%0d got=%0b exp=%0b", ho, hn, a, n, clk_output, e_clk); end
                if (tick !== e_tick)      begin failures++; $display("FAIL recfg_tick ho=%0d hn=%0d a=%0d n=%0d got=%0b exp=%0b", ho, hn, a, n, tick, e_tick); end
                if (cfg_ready !== e_rdy)  begin failures++; $display("FAIL recfg_ready ho=%0d hn=%0d a=%0d n=%0d got=%0b exp=%0b", ho, hn, a, n, cfg_ready, e_rdy); end
            end
            drain(2 * hn + 2);
        end
    endtask

    task automatic test_stop();
        int h, s, f;
        logic run, e_clk, e_tick;
        for (int rep = 0; rep < 6; rep++) begin
            h = (rep < 2) ? 3 : $urandom_range(1, 5);
            s = (rep == 0) ? 4 : (rep == 1) ? 2 : $urandom_range(1, 4 * h);
            // Low when stop arrives: immediate end; high: end at the next scheduled fall.
            if (((s - 1) / h) % 2 == 0) f = s;
            else                        f = ((s + h - 1) / h) * h;
            launch(h, 0);
            for (int n = 1; n <= f + 2; n++) begin
                stop = (n == s) || (n == s + 1);
                step();
                stop = 1'b0;
                run    = (n < f);
                e_clk  = run && (((n / h) % 2) == 1);
                e_tick = e_clk && ((n % h) == 0);
                checks += 4;
                if (clk_output !== e_clk) begin failures++; $display("FAIL stop_clk h=%0d s=%0d n=%0d got=%0b exp=%0b", h, s, n, clk_output, e_clk); end
                if (tick !== e_tick)      begin failures++; $display("FAIL stop_tick h=%0d s=%0d n=%0d got=%0b exp=%0b", h, s, n, tick, e_tick); end
                if (busy !== run)         begin failures++; $display("FAIL stop_busy h=%0d s=%0d n=%0d got=%0b exp=%0b", h, s, n, busy, run); end
                if (done !== (n == f))    begin failures++; $display("FAIL stop_done h=%0d s=%0d n=%0d got=%0b exp=%0b", h, s, n, done, n == f); end
            end
        end
    endtask

    task automatic test_start_stop_idle();
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        for (int n = 0; n < 4; n++) begin
            checks += 3;
            if (busy !== 1'b0)       begin failures++; $display("FAIL ss_busy n=%0d got=%0b exp=0", n, busy); end
            if (clk_output !== 1'b0) begin failures++; $display("FAIL ss_clk n=%0d got=%0b exp=0", n, clk_output); end
            if (done !== 1'b0)       begin failures++; $display("FAIL ss_done n=%0d got=%0b exp=0", n, done); end
            step();
        end
    endtask

    task automatic test_pending_on_stop();
        int hn, a, i;
        logic run, e_clk;
        hn = $urandom_range(1, 5);
        a  = $urandom_range(1, 5);
        launch(3, 0);
        for (int n = 1; n <= a + 1; n++) begin
            cfg_valid = (n == a);
            cfg_half  = CW'(hn);
            cfg_burst = BW'(1);
            stop      = (n == a + 1);
            step();
            cfg_valid = 1'b0;
            cfg_burst = '0;
            stop      = 1'b0;
        end
        i = 0;
        while (busy && i < 8) begin
            step();
            i++;
        end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL pend_idle got busy=%0b required 0", busy); end
        start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 1; n <= 2 * hn + 1; n++) begin
            step();
            run   = (n < 2 * hn);
            e_clk = run && (((n / hn) % 2) == 1);
            checks += 3;
            if (clk_output !== e_clk)   begin failures++; $display("FAIL pend_clk hn=%0d n=%0d got=%0b exp=%0b", hn, n, clk_output, e_clk); end
            if (busy !== run)           begin failures++; $display("FAIL pend_busy hn=%0d n=%0d got=%0b exp=%0b", hn, n, busy, run); end
            if (done !== (n == 2 * hn)) begin failures++; $display("FAIL pend_done hn=%0d n=%0d got=%0b exp=%0b", hn, n, done, n == 2 * hn); end
        end
    endtask

    task automatic test_reset_midrun();
        int i;
        logic e_clk;
        launch(3, 3);
        i = 0;
        while (!clk_output && i < 10) begin
            step();
            i++;
        end
        checks++;
        if (clk_output !== 1'b1) begin failures++; $display("FAIL rstmid_reach got=%0b exp=1", clk_output); end
        rst_n = 1'b0;
        step();
        checks += 6;
        if (clk_output !== 1'b0) begin failures++; $display("FAIL rstmid_clk got=%0b exp=0", clk_output); end
        if (busy !== 1'b0)       begin failures++; $display("FAIL rstmid_busy got=%0b exp=0", busy); end
        if (done !== 1'b0)       begin failures++; $display("FAIL rstmid_done got=%0b exp=0", done); end
        if (tick !== 1'b0)       begin failures++; $display("FAIL rstmid_tick got=%0b exp=0", tick); end
        if (edges_left !== '0)   begin failures++; $display("FAIL rstmid_edges got=%0d exp=0", edges_left); end
        if (cfg_ready !== 1'b1)  begin failures++; $display("FAIL rstmid_ready got=%0b exp=1", cfg_ready); end
        rst_n = 1'b1;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 1; n <= 2 * DEFH + 1; n++) begin
            step();
            e_clk = ((n / DEFH) % 2) == 1;
            checks += 3;
            if (clk_output !== e_clk) begin failures++; $display("FAIL rstmid_defh_clk n=%0d got=%0b exp=%0b", n, clk_output, e_clk); end
            if (edges_left !== '0)    begin failures++; $display("FAIL rstmid_defh_edges n=%0d got=%0d exp=0", n, edges_left); end
            if (busy !== 1'b1)        begin failures++; $display("FAIL rstmid_defh_busy n=%0d got=%0b exp=1", n, busy); end
        end
        drain(2 * DEFH + 2);
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_burst();
        test_reconfig();
        test_stop();
        test_start_stop_idle();
        test_pending_on_stop();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/frec_div_ctrl.md
Name: frec_div_ctrl

Overview:
Run/stop and reconfiguration controller around a programmable frequency-divider core (half-period counter plus toggle flop). Accepts a new divisor through a valid/ready handshake and applies it only at a toggle boundary, so no runt pulse is produced. Supports continuous mode and burst mode (N output periods, then automatic stop), with start/stop and a done indication. Sits between the register/control logic and any block that consumes the divided clock or its tick enable.

Parameters:
CNT_W, 27, width of the half-period counter and of cfg_half.
DEF_HALF, 25000000, half-period in input cycles after reset (1 Hz output from 50 MHz).
BURST_W, 16, width of cfg_burst and edges_left.

Ports:
clk_intput  in  1  input clock; all logic on its rising edge.
rst_n  in  1  synchronous reset, active-low.
cfg_valid  in  1  new configuration offered.
cfg_ready  out  1  configuration can be accepted.
cfg_half  in  CNT_W  half-period H, in input cycles.
cfg_burst  in  BURST_W  number of output periods; 0 selects continuous mode.
start  in  1  begin generating, single-cycle pulse.
stop  in  1  request a glitch-free stop, single-cycle pulse.
clk_output  out  1  divided clock, registered.
tick  out  1  one-cycle pulse coincident with each 0->1 of clk_output.
busy  out  1  high in RUN or STOPPING.
done  out  1  one-cycle pulse on return to IDLE.
edges_left  out  BURST_W  rising edges remaining in burst mode; 0 in continuous mode.

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE; active H=DEF_HALF; burst=0; no pending configuration; count=0; clk_output=0; tick=0; done=0; busy=0; edges_left=0; cfg_ready=1. Reset mid-run aborts immediately, with no done pulse.
- States: IDLE, RUN, STOPPING. busy = (state != IDLE).
- cfg_half=0 is clamped to 1. Output period is always 2H input cycles.
- Configuration in IDLE: cfg_ready=1. A handshake (cfg_valid & cfg_ready) loads active H and burst at that edge.
- Configuration in RUN or STOPPING: cfg_ready=1 only while no configuration is pending. An accepted value is held as pending. It is transferred to active at the next toggle edge and takes effect for the following half-period. cfg_ready returns to 1 on the cycle after the transfer.
- Start: in IDLE, start=1 (with stop=0) moves to RUN with count=0, clk_output=0, and edges_left=burst. If start and a configuration handshake occur in the same cycle, the new configuration is used. start is ignored outside IDLE.
- RUN: count increments each cycle. When count==H-1, clk_output toggles and count goes to 0.
  - With start sampled at edge k, the first rising edge of clk_output occurs at edge k+H, the first falling edge at k+2H, and so on.
  - tick=1 for exactly the cycle in which clk_output has just risen.
  - In burst mode, edges_left decrements on each rising toggle.
- Burst end: on the falling toggle that follows the rising toggle which decremented edges_left to 0, go to IDLE, pulse done, and clear count. clk_output ends low.
- Stop in RUN: if clk_output=0, go to IDLE at the next edge, pulse done, clear count, and leave clk_output at 0. If clk_output=1, go to STOPPING. STOPPING continues counting and, at the falling toggle, goes to IDLE and pulses done. No rising toggle ever occurs in STOPPING.
- Simultaneous events:
  - stop together with burst completion: a single done pulse.
  - start together with stop in IDLE: stop wins and the block stays IDLE.
  - stop in STOPPING: ignored.
  - A pending configuration at the moment of stop: transferred to active on entry to IDLE.
- Width rule: count is CNT_W bits and never exceeds H-1.
- No latency other than the register stages stated above.

Test Plan:
- Reset, then cfg H=2, burst=0, start at edge k -> clk_output=1 on edges k+2..k+3, 0 on k+4..k+5, repeating. tick high only at k+2, k+6, k+10. busy=1.
- cfg H=1, burst=3, start at edge k -> rising edges at k+1, k+3, k+5. edges_left steps 3->2->1->0. Falling edge at k+6 with done=1 at k+6 and busy=0 after it. Exactly 3 tick pulses.
- Running with H=4, offer cfg H=2 mid half-period -> cfg_ready drops. The current half-period still lasts 4 cycles; subsequent half-periods last 2. cfg_ready returns to 1 after the transfer.
- H=3, stop asserted one cycle after a rising edge -> STOPPING. clk_output falls at its normal time (3 cycles after the rise), then done pulses and the block enters IDLE. stop asserted while clk_output=0 -> IDLE and done at the next edge.
- cfg_half=0 with burst=2 -> behaves as H=1: 2 periods of 2 cycles each, then done.
- rst_n=0 mid-RUN with clk_output=1 -> next edge gives clk_output=0, busy=0, done=0, edges_left=0, and DEF_HALF restored.
